bsg_tag_line_bank: RTL and testbench
====================================

Name: bsg_tag_line_bank

Overview:
- Parametrised multi-channel tag client for clock-generator control.
- Deserialises tag packets from one serial tag line and routes each payload to one of els_p contiguous channel registers. Channels are addressed by base_id_p + k.
- Replaces per-line hard-coded clients for the osc/dly/mon line groups.
- Adds channel-count and width generalisation, reset packets, per-channel update strobes and length-error detection.

Parameters:
- els_p, 4, number of channels (tag lines) in the bank; must be >= 1.
- payload_width_p, 12, width of each channel register; 1..(2^lg_width_p - 1).
- id_width_p, 10, width of the packet ID field.
- lg_width_p, 4, width of the packet length field.
- base_id_p, 0, tag ID of channel 0; channel k answers ID base_id_p+k.

Ports:
- clk_i  in  1  tag clock; all state changes on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- en_i  in  1  tag enable; data_i is consumed only on cycles where en_i=1.
- data_i  in  1  serial tag bit.
- data_o  out  els_p*payload_width_p  channel registers; channel k occupies bits [k*payload_width_p +: payload_width_p].
- new_o  out  els_p  one-cycle pulse per channel on a data commit.
- reset_pulse_o  out  els_p  one-cycle pulse per channel on a reset commit.
- err_o  out  1  sticky length-mismatch flag.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset_n_i=0, asynchronous, any state, including mid-packet):
  - all outputs and internal registers go to 0; FSM goes to IDLE.
  - a partial packet is discarded.
- Packet format, bits in order:
  - start bit = 1;
  - id, id_width_p bits, LSB first;
  - dnr, 1 bit (1 = data, 0 = reset);
  - len, lg_width_p bits, LSB first;
  - payload, len bits, LSB first.
- Stalls: a cycle with en_i=0 consumes no bit. The FSM and bit counter hold in every receiving state.
- FSM states:
  - IDLE: on en_i & data_i go to ID with counter=0. Zeros are idle filler.
  - ID: shift in id; after the id_width_p-th bit go to DNR.
  - DNR: latch dnr (1 bit); go to LEN.
  - LEN: shift in len; after the last bit go to PAYLOAD if len!=0, else go to COMMIT.
  - PAYLOAD: shift bit i into shadow[i] for i < payload_width_p. Bits at i >= payload_width_p are consumed and dropped. After the len-th bit go to COMMIT.
  - COMMIT: one cycle; ignores en_i and data_i; always returns to IDLE.
- Shadow register: cleared at entry to ID, so bits not supplied are 0.
- COMMIT decision (k = id - base_id_p; hit = id >= base_id_p and k < els_p):
  - hit & len==payload_width_p & dnr=1: channel k <= shadow; new_o[k]=1 for the cycle after COMMIT.
  - hit & len==payload_width_p & dnr=0: channel k <= 0; reset_pulse_o[k]=1 for the cycle after COMMIT.
  - hit & len!=payload_width_p: no register change; err_o <= 1.
  - no hit: packet ignored silently; err_o unchanged.
- Other channels never change on a commit.
- err_o clears only on reset.
- new_o and reset_pulse_o are at most one-hot and never both set in the same cycle.
- ID arithmetic uses id_width_p+1 bits, so base_id_p+k never wraps.
- Latency:
  - a full packet with en_i held high spans 1+id_width_p+1+lg_width_p+len bit cycles, plus 1 COMMIT cycle;
  - data_o is updated at the COMMIT edge.
- Back-to-back packets: a start bit presented in the COMMIT cycle is not consumed. The next start bit is accepted in IDLE, one cycle later at the earliest.
- busy_o = (state != IDLE).

Test Plan:
- Data commit with defaults, en_i held high:
  - stimulus: id=2, dnr=1, len=12, payload=0xA5C;
  - response: after the 28 bit cycles plus COMMIT, data_o[2] = 0xA5C; new_o = 4'b0100 for exactly one cycle; other channels 0; err_o = 0.
- Reset packet:
  - stimulus: preload channel 1 = 0xFFF, then send id=1, dnr=0, len=12;
  - response: channel 1 = 0; reset_pulse_o = 4'b0010 for one cycle; new_o stays 0.
- Length mismatch:
  - stimulus: id=0, dnr=1, len=5;
  - response: data_o unchanged; err_o = 1 and stays 1 across later good packets until reset_n_i is asserted.
- Out-of-range ID:
  - stimulus: base_id_p=8, send id=12 and id=7;
  - response: no output change; err_o = 0. A following packet with id=9 updates channel 1 correctly.
- Stall:
  - stimulus: data packet id=3 with en_i toggled randomly low (at least 30% of cycles);
  - response: same result as the unstalled case; busy_o stays high from the start bit through COMMIT.
- Async reset mid-packet:
  - stimulus: pull reset_n_i low during PAYLOAD;
  - response: outputs read 0 immediately, with no clock edge needed. After release, a new packet is decoded correctly and no stale shadow bits appear.

Source files
------------

// File: rtl/bsg_tag_line_bank.sv
// Multi-channel tag client: deserialises packets from one serial tag line
// and commits each payload to one of els_p contiguous channel registers.
module bsg_tag_line_bank #(
  parameter int els_p           = 4,
  parameter int payload_width_p = 12,
  parameter int id_width_p      = 10,
  parameter int lg_width_p      = 4,
  parameter int base_id_p       = 0
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               en_i,
  input  logic                               data_i,
  output logic [els_p*payload_width_p-1:0]   data_o,
  output logic [els_p-1:0]                   new_o,
  output logic [els_p-1:0]                   reset_pulse_o,
  output logic                               err_o,
  output logic                               busy_o
);

  // Counter must reach id_width_p-1 and any length up to 2^lg_width_p-1.
  localparam int cnt_w_lp = (($clog2(id_width_p) > lg_width_p) ? $clog2(id_width_p) : lg_width_p) + 1;

  typedef enum logic [2:0] {IDLE, ID, DNR, LEN, PAYLOAD, COMMIT} state_e;

  state_e                             state_r, state_n;
  logic [cnt_w_lp-1:0]                cnt_r, cnt_n;
  logic [id_width_p-1:0]              id_r;
  logic                               dnr_r;
  logic [lg_width_p-1:0]              len_r;
  logic [payload_width_p-1:0]         shadow_r;
  logic [els_p*payload_width_p-1:0]   data_r;
  logic [els_p-1:0]                   new_r;
  logic [els_p-1:0]                   rst_r;
  logic                               err_r;

  // Fields arrive LSB first, so each new bit enters at the top and shifts down.
  logic [id_width_p-1:0]              id_shift;
  logic [lg_width_p-1:0]              len_shift;
  logic [id_width_p:0]                id_ext;
  logic [id_width_p:0]                base_ext;
  logic [id_width_p:0]                idx;
  logic                               hit;
  logic                               len_match;

  assign id_shift  = id_width_p'({data_i, id_r} >> 1);
  assign len_shift = lg_width_p'({data_i, len_r} >> 1);

  // One extra bit keeps base_id_p + k from wrapping.
  assign id_ext    = {1'b0, id_r};
  assign base_ext  = (id_width_p+1)'(base_id_p);
  assign idx       = id_ext - base_ext;
  assign hit       = (id_ext >= base_ext) && (idx < (id_width_p+1)'(els_p));
  assign len_match = (len_r == lg_width_p'(payload_width_p));

  // State and bit counter register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Next-state logic; every receiving state holds while en_i is low.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    case (state_r)
      IDLE: begin
        if (en_i && data_i) begin
          state_n = ID;
          cnt_n   = '0;
        end
      end
      ID: begin
        if (en_i) begin
          if (cnt_r == cnt_w_lp'(id_width_p-1)) begin
            state_n = DNR;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_r + cnt_w_lp'(1);
          end
        end
      end
      DNR: begin
        if (en_i) begin
          state_n = LEN;
          cnt_n   = '0;
        end
      end
      LEN: begin
        if (en_i) begin
          if (cnt_r == cnt_w_lp'(lg_width_p-1)) begin
            cnt_n   = '0;
            state_n = (len_shift != '0) ? PAYLOAD : COMMIT;
          end else begin
            cnt_n = cnt_r + cnt_w_lp'(1);
          end
        end
      end
      PAYLOAD: begin
        if (en_i) begin
          if (cnt_r + cnt_w_lp'(1) == cnt_w_lp'(len_r)) begin
            state_n = COMMIT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_r + cnt_w_lp'(1);
          end
        end
      end
      COMMIT: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Field capture, shadow fill and the commit into the addressed channel.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      id_r     <= '0;
      dnr_r    <= 1'b0;
      len_r    <= '0;
      shadow_r <= '0;
      data_r   <= '0;
      new_r    <= '0;
      rst_r    <= '0;
      err_r    <= 1'b0;
    end else begin
      new_r <= '0;
      rst_r <= '0;
      case (state_r)
        IDLE: begin
          if (en_i && data_i) shadow_r <= '0;
        end
        ID: begin
          if (en_i) id_r <= id_shift;
        end
        DNR: begin
          if (en_i) dnr_r <= data_i;
        end
        LEN: begin
          if (en_i) len_r <= len_shift;
        end
        PAYLOAD: begin
          if (en_i) begin
            for (int j = 0; j < payload_width_p; j++) begin
              if (cnt_r == cnt_w_lp'(j)) shadow_r[j] <= data_i;
            end
          end
        end
        COMMIT: begin
          if (hit) begin
            if (len_match) begin
              for (int k = 0; k < els_p; k++) begin
                if (idx == (id_width_p+1)'(k)) begin
                  data_r[k*payload_width_p +: payload_width_p] <= dnr_r ? shadow_r : '0;
                  new_r[k] <= dnr_r;
                  rst_r[k] <= ~dnr_r;
                end
              end
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign data_o        = data_r;
  assign new_o         = new_r;
  assign reset_pulse_o = rst_r;
  assign err_o         = err_r;
  assign busy_o        = (state_r != IDLE);

endmodule

// File: tb/tb_bsg_tag_line_bank.sv
// Self-checking bench: two banks (base 0 and base 8) share one tag line and
// are compared against a packet-level reference model.
module tb_bsg_tag_line_bank;

  localparam int ELS = 4;
  localparam int PW  = 12;
  localparam int IDW = 10;
  localparam int LGW = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic en;
  logic din;
  logic [ELS*PW-1:0] data_a, data_b;
  logic [ELS-1:0] new_a, new_b, rp_a, rp_b;
  logic err_a, err_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  int busy_drop = 0;

  logic [ELS*PW-1:0] exp_data_a, exp_data_b;
  logic [ELS-1:0] exp_new_a, exp_new_b, exp_rp_a, exp_rp_b;
  logic exp_err_a, exp_err_b;

  bsg_tag_line_bank #(.els_p(ELS), .payload_width_p(PW), .id_width_p(IDW), .lg_width_p(LGW), .base_id_p(0)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .data_i(din),
    .data_o(data_a), .new_o(new_a), .reset_pulse_o(rp_a), .err_o(err_a), .busy_o(busy_a));

  bsg_tag_line_bank #(.els_p(ELS), .payload_width_p(PW), .id_width_p(IDW), .lg_width_p(LGW), .base_id_p(8)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .data_i(din),
    .data_o(data_b), .new_o(new_b), .reset_pulse_o(rp_b), .err_o(err_b), .busy_o(busy_b));

  always #5 clk = ~clk;

  // Reference model of one bank's reaction to a complete packet.
  task automatic model_bank(input int base, input int id, input bit dnr, input int len,
                            input logic [15:0] payload, inout logic [ELS*PW-1:0] d,
                            inout logic e, output logic [ELS-1:0] np, output logic [ELS-1:0] rp);
    int k;
    np = '0;
    rp = '0;
    k = id - base;
    if (id >= base && k < ELS) begin
      if (len == PW) begin
        if (dnr) begin
          d[k*PW +: PW] = payload[PW-1:0];
          np[k] = 1'b1;
        end else begin
          d[k*PW +: PW] = '0;
          rp[k] = 1'b1;
        end
      end else begin
        e = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    exp_data_a = '0; exp_data_b = '0;
    exp_new_a = '0; exp_new_b = '0;
    exp_rp_a = '0; exp_rp_b = '0;
    exp_err_a = 1'b0; exp_err_b = 1'b0;
  endtask

  // Drives one packet starting at a negedge; returns at the negedge after the commit edge.
  task automatic send_packet(input int id, input bit dnr, input int len, input logic [15:0] payload,
                             input int stall_pct, input bit start_in_commit);
    bit q[$];
    q.push_back(1'b1);
    for (int j = 0; j < IDW; j++) q.push_back(id[j]);
    q.push_back(dnr);
    for (int j = 0; j < LGW; j++) q.push_back(len[j]);
    for (int j = 0; j < len; j++) q.push_back(payload[j]);
    for (int i = 0; i < q.size(); i++) begin
      for (int s = 0; s < 8 && $urandom_range(99) < stall_pct; s++) begin
        if (i > 0 && !busy_a) busy_drop++;
        en = 1'b0;
        din = 1'($urandom);
        @(posedge clk); @(negedge clk);
      end
      if (i > 0 && !busy_a) busy_drop++;
      en = 1'b1;
      din = q[i];
      @(posedge clk); @(negedge clk);
    end
    if (!busy_a) busy_drop++;
    en  = start_in_commit ? 1'b1 : 1'($urandom);
    din = start_in_commit ? 1'b1 : 1'($urandom);
    @(posedge clk); @(negedge clk);
    en = 1'b0;
    din = 1'b0;
    model_bank(0, id, dnr, len, payload, exp_data_a, exp_err_a, exp_new_a, exp_rp_a);
    model_bank(8, id, dnr, len, payload, exp_data_b, exp_err_b, exp_new_b, exp_rp_b);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; din = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({data_a, data_b} !== '0) begin errors++; $display("FAIL reset_data: got %h/%h expected 0", data_a, data_b); end
    checks++;
    if ({new_a, new_b, rp_a, rp_b} !== '0) begin errors++; $display("FAIL reset_pulses: got %h expected 0", {new_a, new_b, rp_a, rp_b}); end
    checks++;
    if ({err_a, err_b, busy_a, busy_b} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {err_a, err_b, busy_a, busy_b}); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_data_commit();
    send_packet(2, 1'b1, 12, 16'h0A5C, 0, 1'b0);
    checks++;
    if (data_a !== exp_data_a) begin errors++; $display("FAIL commit_data: got %h expected %h", data_a, exp_data_a); end
    checks++;
    if (new_a !== exp_new_a) begin errors++; $display("FAIL commit_new: got %b expected %b", new_a, exp_new_a); end
    checks++;
    if ({rp_a, err_a, busy_a} !== {exp_rp_a, exp_err_a, 1'b0}) begin errors++; $display("FAIL commit_flags: got %b expected %b", {rp_a, err_a, busy_a}, {exp_rp_a, exp_err_a, 1'b0}); end
    checks++;
    if ({data_b, new_b} !== {exp_data_b, exp_new_b}) begin errors++; $display("FAIL commit_other_bank: got %h expected %h", {data_b, new_b}, {exp_data_b, exp_new_b}); end
    @(posedge clk); @(negedge clk);
    checks++;
    if (new_a !== 4'b0) begin errors++; $display("FAIL commit_new_one_cycle: got %b expected 0000", new_a); end
  endtask

  task automatic test_reset_packet();
    send_packet(1, 1'b1, 12, 16'h0FFF, 0, 1'b0);
    checks++;
    if (data_a !== exp_data_a) begin errors++; $display("FAIL rstpkt_preload: got %h expected %h", data_a, exp_data_a); end
    send_packet(1, 1'b0, 12, 16'($urandom), 0, 1'b0);
    checks++;
    if (data_a !== exp_data_a) begin errors++; $display("FAIL rstpkt_data: got %h expected %h", data_a, exp_data_a); end
    checks++;
    if ({rp_a, new_a} !== {exp_rp_a, exp_new_a}) begin errors++; $display("FAIL rstpkt_pulses: got %b expected %b", {rp_a, new_a}, {exp_rp_a, exp_new_a}); end
    @(posedge clk); @(negedge clk);
    checks++;
    if ({rp_a, new_a} !== 8'b0) begin errors++; $display("FAIL rstpkt_pulse_one_cycle: got %b expected 0", {rp_a, new_a}); end
  endtask

  task automatic test_out_of_range();
    send_packet(12, 1'b1, 12, 16'($urandom), 0, 1'b0);
    send_packet(7, 1'b1, 12, 16'($urandom), 0, 1'b0);
    checks++;
    if ({data_b, new_b, err_b} !== {exp_data_b, exp_new_b, exp_err_b}) begin errors++; $display("FAIL oob_ignored: got %h expected %h", {data_b, new_b, err_b}, {exp_data_b, exp_new_b, exp_err_b}); end
    send_packet(9, 1'b1, 12, 16'($urandom), 0, 1'b0);
    checks++;
    if (data_b !== exp_data_b) begin errors++; $display("FAIL oob_followup_data: got %h expected %h", data_b, exp_data_b); end
    checks++;
    if (new_b !== exp_new_b) begin errors++; $display("FAIL oob_followup_new: got %b expected %b", new_b, exp_new_b); end
  endtask

  task automatic test_len_mismatch();
    send_packet(0, 1'b1, 5, 16'($urandom), 0, 1'b0);
    checks++;
    if (data_a !== exp_data_a) begin errors++; $display("FAIL lenerr_data: got %h expected %h", data_a, exp_data_a); end
    checks++;
    if ({err_a, new_a} !== {exp_err_a, exp_new_a}) begin errors++; $display("FAIL lenerr_flag: got %b expected %b", {err_a, new_a}, {exp_err_a, exp_new_a}); end
    send_packet(3, 1'b1, 12, 16'($urandom), 0, 1'b0);
    checks++;
    if ({data_a, err_a} !== {exp_data_a, exp_err_a}) begin errors++; $display("FAIL lenerr_sticky: got %h expected %h", {data_a, err_a}, {exp_data_a, exp_err_a}); end
  endtask

  task automatic test_stall();
    busy_drop = 0;
    send_packet(3, 1'b1, 12, 16'($urandom), 40, 1'b0);
    checks++;
    if ({data_a, new_a} !== {exp_data_a, exp_new_a}) begin errors++; $display("FAIL stall_data: got %h expected %h", {data_a, new_a}, {exp_data_a, exp_new_a}); end
    checks++;
    if (busy_drop !== 0) begin errors++; $display("FAIL stall_busy: got %0d busy drops expected 0", busy_drop); end
  endtask

  task automatic test_back_to_back();
    send_packet(1, 1'b1, 12, 16'($urandom), 0, 1'b1);
    checks++;
    if ({busy_a, new_a, data_a} !== {1'b0, exp_new_a, exp_data_a}) begin errors++; $display("FAIL b2b_first: got %h expected %h", {busy_a, new_a, data_a}, {1'b0, exp_new_a, exp_data_a}); end
    send_packet(2, 1'b1, 12, 16'($urandom), 0, 1'b0);
    checks++;
    if ({data_a, new_a} !== {exp_data_a, exp_new_a}) begin errors++; $display("FAIL b2b_second: got %h expected %h", {data_a, new_a}, {exp_data_a, exp_new_a}); end
    en = 1'b1; din = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    en = 1'b0;
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL idle_filler_busy: got %b expected 0", busy_a); end
  endtask

  task automatic test_random();
    int id, len;
    bit dnr;
    for (int n = 0; n < 20; n++) begin
      id  = $urandom_range(15);
      dnr = 1'($urandom);
      len = ($urandom_range(3) == 0) ? $urandom_range(15) : 12;
      send_packet(id, dnr, len, 16'($urandom), 20, 1'($urandom));
      checks++;
      if ({data_a, data_b, new_a, new_b, rp_a, rp_b, err_a, err_b} !==
          {exp_data_a, exp_data_b, exp_new_a, exp_new_b, exp_rp_a, exp_rp_b, exp_err_a, exp_err_b}) begin
        errors++;
        $display("FAIL random_pkt id=%0d dnr=%0d len=%0d: got %h expected %h", id, dnr, len,
                 {data_a, data_b, new_a, new_b, rp_a, rp_b, err_a, err_b},
                 {exp_data_a, exp_data_b, exp_new_a, exp_new_b, exp_rp_a, exp_rp_b, exp_err_a, exp_err_b});
      end
    end
  endtask

  task automatic test_async_reset();
    bit q[$];
    send_packet(2, 1'b1, 5, 16'h001F, 0, 1'b0);
    q.push_back(1'b1);
    for (int j = 0; j < IDW; j++) q.push_back(j == 2);
    q.push_back(1'b1);
    for (int j = 0; j < LGW; j++) q.push_back(j == 2 || j == 3);
    for (int j = 0; j < 5; j++) q.push_back(1'b1);
    for (int i = 0; i < q.size(); i++) begin
      en = 1'b1; din = q[i];
      @(posedge clk); @(negedge clk);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({data_a, data_b, new_a, new_b, rp_a, rp_b, err_a, err_b, busy_a, busy_b} !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", {data_a, data_b, new_a, new_b, rp_a, rp_b, err_a, err_b, busy_a, busy_b});
    end
    en = 1'b0; din = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_packet(2, 1'b1, 12, 16'h0030, 0, 1'b0);
    checks++;
    if ({data_a, new_a, err_a} !== {exp_data_a, exp_new_a, exp_err_a}) begin errors++; $display("FAIL async_reset_recover: got %h expected %h", {data_a, new_a, err_a}, {exp_data_a, exp_new_a, exp_err_a}); end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_data_commit();
    test_reset_packet();
    test_out_of_range();
    test_len_mismatch();
    test_stall();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
